// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the load/store unit (master) and data_memory_ctrl (slave).
interface data_memory_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port word RAM behind a valid/ready request/response bus.
// Byte/half/word accesses with sign/zero extension, READ_LAT-cycle loads, and an
// init sequencer that writes INIT_VALUE to every word after reset.
// Optional misalignment checking: define DATA_MEMORY_CTRL_MISALIGN_CHK_EN.
module data_memory_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned READ_LAT   = 1,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    data_memory_ctrl_if.slave bus,
    output logic              init_done_o
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned IDX_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_READ, ST_RESP} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hold_rdata_q, hold_rdata_d;
    logic             hold_err_q, hold_err_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic             init_done_q, init_done_d;

    logic [31:0]      mem_q [DEPTH];
    logic             mem_we_c;
    logic [IDX_W-1:0] mem_idx_c;
    logic [31:0]      mem_wdata_c;
    logic [3:0]       mem_be_c;

    logic [IDX_W-1:0] idx_c;
    logic [1:0]       off_c;
    logic             accept_c;
    logic             misalign_c;
    logic [31:0]      rd_word_c;
    logic [7:0]       rd_byte_c;
    logic [15:0]      rd_half_c;
    logic [31:0]      load_data_c;
    logic [31:0]      st_wdata_c;
    logic [3:0]       st_be_c;
    logic             unused_addr_c;

    // Address decode; upper address bits alias.
    assign idx_c         = bus.req_addr[DEPTH_LOG2+1:2];
    assign off_c         = bus.req_addr[1:0];
    assign accept_c      = bus.req_valid && req_ready_q;
    assign unused_addr_c = ^bus.req_addr[ADDR_W-1:DEPTH_LOG2+2];

`ifdef DATA_MEMORY_CTRL_MISALIGN_CHK_EN
    assign misalign_c = ((bus.req_size == 2'b01) && off_c[0]) ||
                        (bus.req_size[1] && (off_c != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    // Load lane extraction with sign/zero extension.
    always_comb begin
        rd_word_c = mem_q[idx_c];
        rd_byte_c = rd_word_c[{off_c, 3'b000} +: 8];
        rd_half_c = off_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        case (bus.req_size)
            2'b00:   load_data_c = bus.req_signed ? {{24{rd_byte_c[7]}}, rd_byte_c}
                                                  : {24'h0, rd_byte_c};
            2'b01:   load_data_c = bus.req_signed ? {{16{rd_half_c[15]}}, rd_half_c}
                                                  : {16'h0, rd_half_c};
            default: load_data_c = rd_word_c;
        endcase
    end

    // Store lane replication and byte enables.
    always_comb begin
        case (bus.req_size)
            2'b00: begin
                st_wdata_c = {4{bus.req_wdata[7:0]}};
                st_be_c    = 4'b0001 << off_c;
            end
            2'b01: begin
                st_wdata_c = {2{bus.req_wdata[15:0]}};
                st_be_c    = off_c[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata_c = bus.req_wdata;
                st_be_c    = 4'b1111;
            end
        endcase
    end

    // Next-state, RAM write control and registered-output next values.
    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        cnt_d        = cnt_q;
        hold_rdata_d = hold_rdata_q;
        hold_err_d   = hold_err_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        init_done_d  = init_done_q;
        mem_we_c     = 1'b0;
        mem_idx_c    = init_ptr_q;
        mem_wdata_c  = INIT_VALUE;
        mem_be_c     = 4'b1111;

        case (state_q)
            ST_INIT: begin
                mem_we_c   = 1'b1;
                init_ptr_d = init_ptr_q + IDX_W'(1);
                if (init_ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept_c) begin
                    hold_err_d   = misalign_c;
                    hold_rdata_d = (bus.req_write || misalign_c) ? 32'h0 : load_data_c;
                    if (bus.req_write) begin
                        mem_we_c    = !misalign_c;
                        mem_idx_c   = idx_c;
                        mem_wdata_c = st_wdata_c;
                        mem_be_c    = st_be_c;
                        state_d     = ST_RESP;
                    end else if (READ_LAT > 1) begin
                        state_d = ST_READ;
                        cnt_d   = CNT_W'(READ_LAT - 1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = hold_rdata_q;
                    rsp_err_d   = hold_err_q;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            cnt_q        <= '0;
            hold_rdata_q <= 32'h0;
            hold_err_q   <= 1'b0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_err_q    <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            cnt_q        <= cnt_d;
            hold_rdata_q <= hold_rdata_d;
            hold_err_q   <= hold_err_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            init_done_q  <= init_done_d;
        end
    end

    // RAM array write port; the array itself has no reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_c[b]) begin
                    mem_q[mem_idx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign init_done_o   = init_done_q;

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised successor to the single-cycle processor's data memory. Single-port word-organised RAM behind a valid/ready request/response handshake. Supports byte, halfword and word accesses with sign or zero extension, a configurable read latency, and a self-clearing init sequencer in place of a combinational whole-array reset. Sits between the datapath load/store unit and the RAM array, with one transaction outstanding at a time.

Parameters:
ADDR_W, 32, request byte-address width
DEPTH_LOG2, 8, log2 of the number of 32-bit words (DEPTH = 2**DEPTH_LOG2)
READ_LAT, 1, cycles from read accept to rsp_valid; legal range 1..4
INIT_VALUE, 32'h00000000, word written to every location by the init sequencer

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
req_signed  in  1  sign-extend byte/half loads
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, LSB-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  load data (0 for stores)
rsp_err  out  1  access error (only with optional feature, else tied 0)
init_done  out  1  memory initialisation complete

Behaviour:
- Reset: reset is asynchronous, active-low. While reset==0: state=INIT, init_ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0. The RAM array itself is not asynchronously reset.
- States: INIT, IDLE, READ, RESP.
- INIT:
  - Each cycle writes INIT_VALUE to RAM[init_ptr] and increments init_ptr.
  - After writing DEPTH-1, transitions to IDLE and sets init_done=1. init_done stays 1 until the next reset.
  - INIT lasts exactly DEPTH cycles after reset deassertion.
- IDLE: req_ready=1 only in IDLE. A request is accepted on a rising edge where req_valid && req_ready.
- Word index = req_addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH bytes.
- Store:
  - Written on the accept edge.
  - Byte: lane addr[1:0] <= wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0].
  - Word: all lanes <= wdata.
  - Other lanes are unchanged.
  - Next state RESP; rsp_valid rises 1 cycle after accept with rsp_rdata=0.
- Load:
  - The word is snapshotted on the accept edge.
  - Next state READ with a down-counter of READ_LAT-1; if READ_LAT=1, go directly to RESP.
  - rsp_valid rises exactly READ_LAT cycles after the accept edge.
  - Extraction: the selected lane is shifted to bit 0. It is sign-extended if req_signed, else zero-extended. Word loads ignore req_signed.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On the rsp_valid && rsp_ready edge: rsp_valid <= 0, state <= IDLE.
  - A new request can be accepted no earlier than the cycle after the handshake.
- One outstanding transaction: req_ready=0 in INIT, READ and RESP. req_valid held during those states is ignored, not lost; it is accepted once IDLE is reached.
- Ordering: a load following a store to the same word returns the updated data.
- Reset mid-operation: any pending response is discarded and the controller re-enters INIT. Store data already written stays written until overwritten by INIT.

Optional Feature:
- Macro: DATA_MEMORY_CTRL_MISALIGN_CHK_EN.
- Defined:
  - A half access with addr[0]!=0, or a word access with addr[1:0]!=0, is misaligned.
  - A misaligned access writes nothing and returns rsp_err=1, rsp_rdata=0, with the normal latency (store 1 cycle, load READ_LAT).
  - Aligned accesses return rsp_err=0.
- Undefined:
  - No check; offending low address bits are ignored (half uses addr[1], word ignores addr[1:0]).
  - rsp_err is tied 0.

Test Plan:
- Init: release reset, DEPTH=256 -> req_ready=0 and init_done=0 for 256 cycles, then both 1. A word load from 0x3FC returns INIT_VALUE.
- Word store/load: store 0xDEADBEEF at 0x10, then load word 0x10 with READ_LAT=3 -> rsp_valid exactly 3 cycles after accept, rdata=0xDEADBEEF.
- Sub-word: byte store 0x80 at 0x21 over a word 0 -> signed byte load 0x21 = 0xFFFFFF80, unsigned = 0x00000080, word load 0x20 = 0x00008000.
- Backpressure/aliasing: hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0. Store to 0x400 (DEPTH=256) -> a load from 0x000 returns the same data.
- Reset mid-read: deassert-then-assert reset during READ -> rsp_valid=0 immediately, state INIT, no stale response after init.
- Misalign (macro on): word load at 0x12 -> rsp_err=1, rdata=0. Half store at 0x13 leaves the memory word unchanged. Macro off: the same word load returns the word at 0x10 with rsp_err=0.
